fsync_serial_tx: RTL and testbench
==================================

Name: fsync_serial_tx

Overview:
Frame-sync serial transmitter that emulates the master-mode ADC data port. It accepts 24-bit samples on an AXI-Stream slave and generates sck, fsync and dout, MSB-first, in 32-bit frames. It serves as the ADC model for hardware-in-loop loopback of the capture path, and as a serial source toward DAC-style sinks. Frame timing matches the capture side: data changes on sck falling, is sampled on sck rising, and fsync marks bit 0.

Parameters:
DW, 24, sample width in bits; data bits occupy frame bits 0..DW-1.
FRAME_SCK, 32, sck periods per frame; must be >= DW (>= DW+8 when the optional feature is compiled in).
SCK_HALF, 2, clk cycles per sck half-period; must be >= 1. sck period = 2*SCK_HALF clk.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  run enable
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  sample accept, single-cycle pulse at frame load
s_axis_tdata  in  DW  sample, two's complement
sck  out  1  serial clock, registered
fsync  out  1  frame sync, high for the whole first sck period of a frame
dout  out  1  serial data, registered
underrun_cnt  out  16  saturating count of frames sent without a fresh sample
busy  out  1  high while not IDLE

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. While rst_n=0, all outputs are 0, the FSM is IDLE, all counters are 0 and the held sample is 0. Reset mid-frame aborts immediately; no partial-frame completion.
- Counters:
  - div_cnt runs 0..2*SCK_HALF-1.
  - sck=1 when div_cnt >= SCK_HALF (registered, so it is low for the first half).
  - bit_cnt runs 0..FRAME_SCK-1 and increments when div_cnt wraps.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: sck=0, fsync=0, dout=0. Goes to LOAD when en=1.
  - LOAD: one cycle. Then SHIFT with div_cnt=0, bit_cnt=0.
  - SHIFT: runs frames back-to-back with no gap.
  - Boundary cycle: bit_cnt=FRAME_SCK-1 and div_cnt=2*SCK_HALF-1.
  - At a boundary cycle: if en=1, reload in that same cycle and stay in SHIFT. If en=0, go to IDLE (the current frame always completes).
- Load / handshake:
  - s_axis_tready=1 only in the LOAD state cycle and in boundary cycles where en=1; otherwise 0.
  - tready does not depend on tvalid.
  - If tvalid=1 in a load cycle: capture tdata into the shift register and held sample.
  - If tvalid=0 in a load cycle: resend the held sample and increment underrun_cnt, saturating at 0xFFFF.
- Output timing: dout and fsync update only on the clk where sck goes low (div_cnt wraps to 0, or entry from LOAD).
  - fsync=1 throughout bit_cnt=0.
  - dout = sample bit DW-1-bit_cnt for bit_cnt < DW; 0 for the remaining bits (unless the optional feature is compiled in).
- Latency: the first sck falling edge, with fsync=1 and dout=MSB, occurs one clk after the load cycle.
- Frame period: FRAME_SCK*2*SCK_HALF clk cycles. A capture-side receiver outputs frame N's data at the fsync rising edge of frame N+1.
- Simultaneous events:
  - en falling during LOAD: the frame is still sent.
  - tvalid arriving mid-frame: waits, unconsumed, for the next boundary.
- busy=1 in LOAD and SHIFT.

Optional Feature:
FSYNC_TX_FRAME_CNT_EN
- Defined: an 8-bit frame counter is transmitted MSB-first in frame bits DW..DW+7.
  - The counter resets to 0, increments after every completed frame and wraps 255 to 0.
  - Bits DW+8 and above are 0.
- Undefined: all bits from DW upward are 0 and no counter exists.

Test Plan:
1. SCK_HALF=2, FRAME_SCK=32, en=1, one sample 0xA5C3F0 -> exactly one tready pulse; fsync high 4 clk; dout MSB-first 1010_0101_1100_0011_1111_0000 then 8 zeros; frame length 128 clk.
2. Loopback into the ADC capture receiver with 0x7FFFFF, 0x800000, 0x000001 streamed continuously -> receiver tdata shows the same three values, each appearing one frame later, no gaps; underrun_cnt=0.
3. Send 0x123456, then hold tvalid=0 for 3 frames -> 0x123456 repeated 3 times; underrun_cnt=3; a later sample loads at the next boundary.
4. Drop en at bit_cnt=10 -> frame completes through bit 31; then IDLE with sck=fsync=dout=0, busy=0, no tready.
5. Assert rst_n=0 at bit_cnt=5 -> next clk all outputs 0 and FSM IDLE; after release with en=1, LOAD then a fresh frame starts from bit 0.
6. With FSYNC_TX_FRAME_CNT_EN defined, 3 frames of 0x000000 -> bits 24..31 carry 0x00, 0x01, 0x02; after 256 frames the counter wraps to 0x00.

Source files
------------

// File: rtl/fsync_serial_tx_if.sv
// AXI-Stream sample channel feeding the frame-sync serial transmitter.
interface fsync_serial_tx_if #(
  parameter int DW = 24
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fsync_serial_tx.sv
// Frame-sync serial transmitter: emulates a master-mode ADC data port (sck/fsync/dout, MSB-first).
// Optional macro FSYNC_TX_FRAME_CNT_EN appends an 8-bit frame counter after the sample bits.
//
// state | meaning
// IDLE  | outputs low, waiting for en
// LOAD  | one cycle: take a sample (or reuse the held one), tready high
// SHIFT | frames back-to-back; reload or stop at each frame boundary
module fsync_serial_tx #(
  parameter int DW        = 24,
  parameter int FRAME_SCK = 32,
  parameter int SCK_HALF  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  fsync_serial_tx_if.slave    s_axis,
  output logic                sck,
  output logic                fsync,
  output logic                dout,
  output logic [15:0]         underrun_cnt,
  output logic                busy
);

  localparam int DIV_W = (2 * SCK_HALF > 1) ? $clog2(2 * SCK_HALF) : 1;
  localparam int BIT_W = (FRAME_SCK > 1) ? $clog2(FRAME_SCK) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_SCK - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [DIV_W-1:0]       div_cnt, div_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_nxt;
  logic [FRAME_SCK-1:0]   shreg;
  logic [FRAME_SCK-1:0]   frame_word;
  logic [DW-1:0]          held;
  logic [DW-1:0]          sample_sel;
  logic                   load;
  logic                   wrap;

`ifdef FSYNC_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt;
  logic [7:0] fcnt_sel;
  // A reload at a boundary carries the number of the frame that starts now.
  assign fcnt_sel = (state == SHIFT) ? frame_cnt + 8'd1 : frame_cnt;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    wrap      = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = SHIFT;
        div_nxt   = '0;
        bit_nxt   = '0;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          wrap    = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
            if (en) load = 1'b1;
            else    state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sample_sel = s_axis.tvalid ? s_axis.tdata : held;

  always_comb begin
    frame_word = '0;
    frame_word[FRAME_SCK-1 -: DW] = sample_sel;
`ifdef FSYNC_TX_FRAME_CNT_EN
    frame_word[FRAME_SCK-1-DW -: 8] = fcnt_sel;
`endif
  end

  assign s_axis.tready = rst_n & load;
  assign busy          = rst_n & (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      held         <= '0;
      sck          <= 1'b0;
      fsync        <= 1'b0;
      dout         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      sck     <= (state_nxt == SHIFT) && (div_nxt >= DIV_HALF);
      if (load) begin
        shreg <= frame_word << 1;
        dout  <= frame_word[FRAME_SCK-1];
        fsync <= 1'b1;
        if (s_axis.tvalid) held <= s_axis.tdata;
        else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end else if (wrap) begin
        fsync <= 1'b0;
        if (state_nxt == IDLE) begin
          dout <= 1'b0;
        end else begin
          dout  <= shreg[FRAME_SCK-1];
          shreg <= shreg << 1;
        end
      end
    end
  end

`ifdef FSYNC_TX_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt <= '0;
    else if (wrap && bit_cnt == BIT_LAST) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fsync_serial_tx.sv
// Directed bench for fsync_serial_tx: vector table of samples plus stop and mid-frame reset sequences.
module tb_fsync_serial_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sck, fsync, dout, busy;
  logic [15:0] underrun_cnt;

  fsync_serial_tx_if #(.DW(24)) s_axis ();

  fsync_serial_tx #(.DW(24), .FRAME_SCK(32), .SCK_HALF(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .s_axis       (s_axis),
    .sck          (sck),
    .fsync        (fsync),
    .dout         (dout),
    .underrun_cnt (underrun_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic [23:0] exp_s;
    logic [15:0] exp_und;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int tready_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present one sample (or none) and wait for the load cycle that consumes it.
  task automatic push(input vec_t t);
    logic got;
    got = 1'b0;
    s_axis.tvalid = t.v;
    s_axis.tdata  = t.d;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (s_axis.tready) got = 1'b1;
    end
    chk("tready_seen", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    if (got) begin
      n_push++;
      exp_q.push_back({t.exp_s, 8'h00});
      chk("underrun", {16'b0, underrun_cnt}, {16'b0, t.exp_und});
      chk("lat_fsync", {31'b0, fsync}, 32'd1);
      chk("lat_msb", {31'b0, dout}, {31'b0, t.exp_s[23]});
      chk("lat_sck", {31'b0, sck}, 32'd0);
    end
  endtask

  // Count cycles from the first SHIFT cycle until IDLE, dropping en at bit_cnt ~10.
  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 42) en = 1'b0;
      if (!busy) break;
    end
    chk(name, n, 128);
    chk("idle_sck", {31'b0, sck}, 32'd0);
    chk("idle_fsync", {31'b0, fsync}, 32'd0);
    chk("idle_dout", {31'b0, dout}, 32'd0);
  endtask

  // Serial receiver model: sample dout on sck rising, fsync marks bit 0.
  logic prev_sck = 1'b0, prev_fsync = 1'b0, have_rise = 1'b0;
  logic [31:0] word = '0;
  int bitn = 0, cyc = 0, last_rise = 0, fw = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bitn = 0;
      have_rise = 1'b0;
      fw = 0;
    end else begin
      if (sck && !prev_sck) begin
        if (fsync) begin
          word = {31'b0, dout};
          bitn = 1;
        end else if (bitn > 0) begin
          word = {word[30:0], dout};
          bitn++;
        end
        if (bitn == 32) begin
          cap_q.push_back(word);
          bitn = 0;
        end
      end
      if (fsync && !prev_fsync) begin
        if (have_rise) chk("frame_len", cyc - last_rise, 128);
        last_rise = cyc;
        have_rise = 1'b1;
        fw = 0;
      end
      if (fsync) fw++;
      if (!fsync && prev_fsync) chk("fsync_width", fw, 4);
      if (!busy && !fsync) have_rise = 1'b0;
      if (s_axis.tready) tready_cnt++;
    end
    prev_sck   = sck;
    prev_fsync = fsync;
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t rv;
    int idle_tr;
    tbl[0] = '{1'b1, 24'hA5C3F0, 24'hA5C3F0, 16'd0};
    tbl[1] = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 16'd0};
    tbl[2] = '{1'b1, 24'h800000, 24'h800000, 16'd0};
    tbl[3] = '{1'b1, 24'h000001, 24'h000001, 16'd0};
    tbl[4] = '{1'b1, 24'h123456, 24'h123456, 16'd0};
    tbl[5] = '{1'b0, 24'hFFFFFF, 24'h123456, 16'd1};
    tbl[6] = '{1'b0, 24'h000000, 24'h123456, 16'd2};
    tbl[7] = '{1'b0, 24'h0F0F0F, 24'h123456, 16'd3};
    tbl[8] = '{1'b1, 24'hABCDEF, 24'hABCDEF, 16'd3};

    rst_n = 1'b0;
    en = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {28'b0, sck, fsync, dout, busy}, 32'd0);
    chk("rst_tready", {31'b0, s_axis.tready}, 32'd0);
    chk("rst_underrun", {16'b0, underrun_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {31'b0, busy}, 32'd0);

    en = 1'b1;
    for (int i = 0; i < 9; i++) push(tbl[i]);
    finish_frame("stop_len");
    chk("stop_busy", {31'b0, busy}, 32'd0);
    idle_tr = 0;
    repeat (50) begin
      @(negedge clk);
      if (s_axis.tready || busy) idle_tr++;
    end
    chk("idle_quiet", idle_tr, 0);

    // Mid-frame reset: the aborted frame is never expected on the wire.
    en = 1'b1;
    rv = '{1'b1, 24'h555555, 24'h555555, 16'd3};
    push(rv);
    void'(exp_q.pop_back());
    repeat (21) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_outs", {28'b0, sck, fsync, dout, busy}, 32'd0);
    chk("mrst_tready", {31'b0, s_axis.tready}, 32'd0);
    chk("mrst_underrun", {16'b0, underrun_cnt}, 32'd0);
    rst_n = 1'b1;
    rv = '{1'b1, 24'h0000FF, 24'h0000FF, 16'd0};
    push(rv);
    finish_frame("restart_len");

    repeat (10) @(posedge clk);
    chk("tready_pulses", tready_cnt, n_push);
    chk("frame_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("frame%0d", i), cap_q[i], exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
